// File: rtl/conv_pkg.sv
// Shared constants and types for the CONV host memory slice.
// Holds the data/address widths, memory depths, bank-select codes and the
// host sequencer state encoding used by conv_mem_host.
package conv_pkg;

   localparam int DW        = 20;     // signed 4.16 fixed point word
   localparam int AW        = 12;     // image / layer address width
   localparam int IMG_WORDS = 4096;   // 64x64 image and L0 depth
   localparam int L1_WORDS  = 1024;   // 32x32 L1 depth
   localparam int L1_AW     = $clog2(L1_WORDS);

   localparam logic [2:0] CSEL_NONE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;

   localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] IMG_LAST = AW'(IMG_WORDS - 1);
   localparam logic [AW-1:0] L1_LAST  = AW'(L1_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_START   = 3'd2,
      ST_RUN     = 3'd3,
      ST_DUMP_L0 = 3'd4,
      ST_DUMP_L1 = 3'd5,
      ST_DONE    = 3'd6
   } host_state_e;

endpackage

// File: rtl/conv_bank_ram.sv
// Single-write-port memory bank with NRD asynchronous read ports.
// Ports:
//   clk   - write clock
//   we    - write enable, sampled on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - NRD packed read addresses
//   rdata - NRD packed read data, combinational from the array
// A read of the address being written returns the old contents until the
// write edge has passed.
module conv_bank_ram #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4096,
   parameter int NRD    = 1,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [NRD-1:0][ADDR_W-1:0]  raddr,
   output logic [NRD-1:0][DATA_W-1:0]  rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write port: contents are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rdata[i] = mem_r[raddr[i]];
      end
   end

endmodule

// File: rtl/conv_mem_host.sv
// Host-side memory owner and job sequencer for the CONV accelerator.
// Streams a 64x64 image into the image ROM, requests a job, serves the
// accelerator's image/layer accesses while it runs, then streams L0 followed
// by L1 out over a valid/ready interface.
// Ports:
//   clk, reset                    - clock, async active-high reset
//   in_valid/in_ready/in_data     - image input stream (raster order)
//   ready, busy                   - job start request / CONV busy
//   iaddr, idata                  - combinational image read
//   crd, caddr_rd, cdata_rd       - combinational layer read (crd advisory)
//   cwr, caddr_wr, cdata_wr, csel - layer write, honoured only while running
//   out_valid/out_ready/out_data  - result stream, L0[0..4095] then L1[0..1023]
//   out_last                      - marks the final L1 word
//   done                          - one-cycle pulse after the final handshake
module conv_mem_host
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic [2:0]    csel,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          done
);

   host_state_e state_r, state_nxt_s;
   logic [AW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
   logic          in_ready_r, ready_r, done_r;
   logic          out_valid_r, out_valid_nxt_s;
   logic          out_last_r, out_last_nxt_s;
   logic [DW-1:0] out_data_r, out_data_nxt_s;
   logic          img_we_s, l0_we_s, l1_we_s;
   logic [AW-1:0]    l0_dump_addr_s;
   logic [L1_AW-1:0] l1_dump_addr_s;
   logic [0:0][DW-1:0] img_rdata_s;
   logic [1:0][DW-1:0] l0_rdata_s, l1_rdata_s;
   logic          unused_crd_s;

   // crd carries no timing meaning for these asynchronous banks.
   assign unused_crd_s = crd;

   assign cnt_inc_s = cnt_r + CNT_ONE;
   assign l0_we_s   = cwr && (state_r == ST_RUN) && (csel == CSEL_L0);
   assign l1_we_s   = cwr && (state_r == ST_RUN) && (csel == CSEL_L1);

   // Dump read addresses: fetch the current word while the output register is
   // empty, otherwise prefetch the next one so a handshake can refill it with
   // no bubble. L1 word 0 is prefetched during L0 for the bank crossover.
   always_comb begin
      l0_dump_addr_s = out_valid_r ? cnt_inc_s : cnt_r;
      if (state_r == ST_DUMP_L1) begin
         l1_dump_addr_s = out_valid_r ? cnt_inc_s[L1_AW-1:0] : cnt_r[L1_AW-1:0];
      end else begin
         l1_dump_addr_s = '0;
      end
   end

   conv_bank_ram #(.DATA_W(DW), .DEPTH(IMG_WORDS), .NRD(1)) u_img (
      .clk   (clk),
      .we    (img_we_s),
      .waddr (cnt_r),
      .wdata (in_data),
      .raddr (iaddr),
      .rdata (img_rdata_s)
   );

   // Port 1 serves the CONV, port 0 serves the result stream.
   conv_bank_ram #(.DATA_W(DW), .DEPTH(IMG_WORDS), .NRD(2)) u_l0 (
      .clk   (clk),
      .we    (l0_we_s),
      .waddr (caddr_wr),
      .wdata (cdata_wr),
      .raddr ({caddr_rd, l0_dump_addr_s}),
      .rdata (l0_rdata_s)
   );

   conv_bank_ram #(.DATA_W(DW), .DEPTH(L1_WORDS), .NRD(2)) u_l1 (
      .clk   (clk),
      .we    (l1_we_s),
      .waddr (caddr_wr[L1_AW-1:0]),
      .wdata (cdata_wr),
      .raddr ({caddr_rd[L1_AW-1:0], l1_dump_addr_s}),
      .rdata (l1_rdata_s)
   );

   assign idata = img_rdata_s[0];

   // Layer read mux; unselected banks read as zero.
   always_comb begin
      case (csel)
         CSEL_L0:   cdata_rd = l0_rdata_s[1];
         CSEL_L1:   cdata_rd = l1_rdata_s[1];
         CSEL_NONE: cdata_rd = '0;
         default:   cdata_rd = '0;
      endcase
   end

   // Sequencer next-state, counter and result-register logic.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      out_valid_nxt_s = out_valid_r;
      out_data_nxt_s  = out_data_r;
      out_last_nxt_s  = out_last_r;
      img_we_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_LOAD;
            cnt_nxt_s   = '0;
         end
         ST_LOAD: begin
            if (in_valid && in_ready_r) begin
               img_we_s = 1'b1;
               if (cnt_r == IMG_LAST) begin
                  state_nxt_s = ST_START;
                  cnt_nxt_s   = '0;
               end else begin
                  cnt_nxt_s = cnt_inc_s;
               end
            end else begin
               img_we_s = 1'b0;
            end
         end
         ST_START: begin
            if (busy) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_RUN: begin
            if (!busy) begin
               state_nxt_s     = ST_DUMP_L0;
               cnt_nxt_s       = '0;
               out_valid_nxt_s = 1'b0;
               out_last_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DUMP_L0: begin
            if (!out_valid_r) begin
               out_data_nxt_s  = l0_rdata_s[0];
               out_valid_nxt_s = 1'b1;
            end else if (out_ready) begin
               if (cnt_r == IMG_LAST) begin
                  state_nxt_s    = ST_DUMP_L1;
                  cnt_nxt_s      = '0;
                  out_data_nxt_s = l1_rdata_s[0];
                  out_last_nxt_s = 1'b0;
               end else begin
                  cnt_nxt_s      = cnt_inc_s;
                  out_data_nxt_s = l0_rdata_s[0];
               end
            end else begin
               out_valid_nxt_s = out_valid_r;
            end
         end
         ST_DUMP_L1: begin
            if (!out_valid_r) begin
               out_data_nxt_s  = l1_rdata_s[0];
               out_valid_nxt_s = 1'b1;
               out_last_nxt_s  = (cnt_r == L1_LAST);
            end else if (out_ready) begin
               if (cnt_r == L1_LAST) begin
                  state_nxt_s     = ST_DONE;
                  cnt_nxt_s       = '0;
                  out_valid_nxt_s = 1'b0;
                  out_last_nxt_s  = 1'b0;
               end else begin
                  cnt_nxt_s      = cnt_inc_s;
                  out_data_nxt_s = l1_rdata_s[0];
                  out_last_nxt_s = (cnt_inc_s == L1_LAST);
               end
            end else begin
               out_valid_nxt_s = out_valid_r;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; strobes are decoded from the next state so
   // they line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         in_ready_r  <= 1'b0;
         ready_r     <= 1'b0;
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_LOAD);
         ready_r     <= (state_nxt_s == ST_START);
         done_r      <= (state_nxt_s == ST_DONE);
         out_valid_r <= out_valid_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_last_r  <= out_last_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign ready     = ready_r;
   assign done      = done_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed self-checking bench for conv_mem_host.
module tb_conv_mem_host;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_data;
   logic        ready;
   logic        busy;
   logic [11:0] iaddr;
   logic [19:0] idata;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [19:0] cdata_rd;
   logic        cwr;
   logic [11:0] caddr_wr;
   logic [19:0] cdata_wr;
   logic [2:0]  csel;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_data;
   logic        out_last;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0] exp_l0 [4096];
   logic [19:0] exp_l1 [1024];

   conv_mem_host dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ready(ready), .busy(busy),
      .iaddr(iaddr), .idata(idata),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] exp_word(input int k);
      if (k < 4096) return exp_l0[k];
      else return exp_l1[k - 4096];
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  in_ready,  1);
      check({tag, "_ready"},     ready,     0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  out_data,  0);
      check({tag, "_out_last"},  out_last,  0);
      check({tag, "_done"},      done,      0);
   endtask

   initial begin
      int idx;
      int cyc;
      int done_cnt;
      logic prev_stall;
      logic [19:0] prev_data;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; busy = 1'b0; iaddr = '0;
      crd = 1'b0; caddr_rd = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
      csel = 3'b000; out_ready = 1'b0;
      #1;
      check("rst_in_ready",  in_ready,  0);
      check("rst_ready",     ready,     0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_last",  out_last,  0);
      check("rst_done",      done,      0);
      step(); step(); step();
      reset = 1'b0;
      step();   // IDLE -> LOAD
      check("load_entry_in_ready", in_ready, 1);
      check("load_entry_ready", ready, 0);

      // Ramp image load.
      for (int i = 0; i < 4096; i++) begin
         in_valid = 1'b1;
         in_data  = 20'(i);
         check("load_in_ready", in_ready, 1);
         step();
      end
      check("load_end_in_ready", in_ready, 0);
      check("load_end_ready", ready, 1);

      // START: stream words are not acknowledged here.
      in_valid = 1'b1;
      in_data  = 20'hFFFFF;
      iaddr = 12'h0A5; #1;
      check("idata_0a5", idata, 20'h000A5);
      iaddr = 12'hFFF; #1;
      check("idata_fff", idata, 20'h00FFF);
      for (int i = 0; i < 3; i++) begin
         check("start_ready_held", ready, 1);
         check("start_no_in_ready", in_ready, 0);
         step();
      end
      busy = 1'b1;
      check("start_ready_before_busy_edge", ready, 1);
      step();   // START -> RUN
      check("run_ready_low", ready, 0);
      in_valid = 1'b0;
      iaddr = 12'h000; #1;
      check("run_idata_0_untouched", idata, 20'h00000);

      // Fill L0 and L1 from the CONV side.
      for (int a = 0; a < 4096; a++) begin
         exp_l0[a] = 20'h40000 + 20'(a);
         cwr = 1'b1; csel = 3'b001; caddr_wr = 12'(a); cdata_wr = exp_l0[a];
         step();
      end
      for (int a = 0; a < 1024; a++) begin
         exp_l1[a] = 20'hC0000 + 20'(a * 3);
         cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(a); cdata_wr = exp_l1[a];
         step();
      end
      cwr = 1'b0;
      csel = 3'b001; caddr_rd = 12'd5; #1;
      check("l0_rd_5_fill", cdata_rd, exp_l0[5]);
      csel = 3'b011; caddr_rd = 12'd1023; #1;
      check("l1_rd_3ff_fill", cdata_rd, exp_l1[1023]);

      // Read-during-write: old value this cycle, new value next.
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'h12345; caddr_rd = 12'd5; #1;
      check("rdw_old", cdata_rd, exp_l0[5]);
      step();
      exp_l0[5] = 20'h12345;
      cwr = 1'b0; #1;
      check("rdw_new", cdata_rd, 20'h12345);

      // Unmapped bank select: write ignored, read returns zero.
      cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd5; cdata_wr = 20'hFFFFF;
      step();
      cwr = 1'b0;
      #1;
      check("csel010_rd_zero", cdata_rd, 0);
      csel = 3'b001; #1;
      check("csel010_l0_kept", cdata_rd, 20'h12345);
      csel = 3'b011; #1;
      check("csel010_l1_kept", cdata_rd, exp_l1[5]);
      csel = 3'b000; #1;
      check("csel000_rd_zero", cdata_rd, 0);

      // L1 address wraps onto its 10-bit range.
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h7FF; cdata_wr = 20'hABCDE;
      step();
      exp_l1[1023] = 20'hABCDE;
      cwr = 1'b0; caddr_rd = 12'h3FF; #1;
      check("l1_wrap_rd_3ff", cdata_rd, 20'hABCDE);
      caddr_rd = 12'h7FF; #1;
      check("l1_wrap_rd_7ff", cdata_rd, 20'hABCDE);
      check("run_out_valid_low", out_valid, 0);

      // Busy falls: RUN -> DUMP_L0, output register empty on entry.
      busy = 1'b0;
      step();
      check("dump_entry_out_valid", out_valid, 0);
      // Writes outside RUN must be ignored.
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd0; cdata_wr = 20'hDEAD0;

      idx = 0; cyc = 0; done_cnt = 0; prev_stall = 1'b0; prev_data = '0;
      while (idx < 5120 && cyc < 20000) begin
         out_ready = (cyc % 2 == 0);
         #1;
         if (done) done_cnt++;
         if (prev_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_held", out_data, prev_data);
         end
         if (idx > 0) check("no_bubble", out_valid, 1);
         if (out_valid && out_ready) begin
            check("dump_data", out_data, exp_word(idx));
            check("dump_last", out_last, (idx == 5119) ? 1 : 0);
            idx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (idx == 1 && cyc < 4) cwr = 1'b0;
         step();
         cyc++;
      end
      cwr = 1'b0;
      out_ready = 1'b0;
      check("dump_word_count", idx, 5120);
      check("done_not_early", done_cnt, 0);
      check("final_done", done, 1);
      check("final_out_valid", out_valid, 0);
      check("final_out_last", out_last, 0);
      step();   // DONE -> IDLE
      check("done_pulse_ends", done, 0);
      step();   // IDLE -> LOAD
      check("reload_in_ready", in_ready, 1);

      // Partial load, then reset mid-stream.
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = 20'hF0000 + 20'(i);
         step();
      end
      reset = 1'b1;
      #1;
      check("midrst_in_ready",  in_ready,  0);
      check("midrst_ready",     ready,     0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data",  out_data,  0);
      check("midrst_out_last",  out_last,  0);
      check("midrst_done",      done,      0);
      step(); step();
      reset = 1'b0;
      step();   // IDLE -> LOAD
      check_reset_outputs("restart");
      for (int i = 0; i < 4096; i++) begin
         in_valid = 1'b1;
         in_data  = 20'h55555 ^ 20'(i);
         check("reload_in_ready_each", in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      check("reload_end_in_ready", in_ready, 0);
      check("reload_end_ready", ready, 1);
      iaddr = 12'h000; #1;
      check("reload_idata_000", idata, 20'h55555);
      iaddr = 12'h063; #1;
      check("reload_idata_063", idata, 20'h55536);
      iaddr = 12'hFFF; #1;
      check("reload_idata_fff", idata, 20'h55AAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
- Host-side counterpart of the CONV layer accelerator.
- Owns the image ROM, layer-0 RAM and layer-1 RAM. Answers the accelerator's iaddr/idata, caddr_rd/cdata_rd and cwr/caddr_wr/cdata_wr/csel accesses.
- Sequences a full job: stream the 64x64 image in, raise ready, wait for busy to fall, then stream L0 and L1 results out.
- Sits between the system stream fabric and the CONV engine.

Parameters:
- DW, 20, data word width (signed fixed point, 4.16)
- AW, 12, address width
- IMG_WORDS, 4096, image / L0 depth (64x64)
- L1_WORDS, 1024, L1 depth (32x32)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  image word valid
- in_ready  out  1  image word accepted when in_valid & in_ready
- in_data  in  DW  image word, raster order
- ready  out  1  job start request to CONV
- busy  in  1  CONV busy
- iaddr  in  AW  image read address
- idata  out  DW  image[iaddr], combinational
- crd  in  1  layer read enable
- caddr_rd  in  AW  layer read address
- cdata_rd  out  DW  layer read data, combinational
- cwr  in  1  layer write enable
- caddr_wr  in  AW  layer write address
- cdata_wr  in  DW  layer write data
- csel  in  3  bank select: 3'b001=L0, 3'b011=L1, others=none
- out_valid  out  1  result word valid
- out_ready  in  1  result word consumed
- out_data  out  DW  result word
- out_last  out  1  high on final L1 word
- done  out  1  one-cycle pulse after final result handshake

Behaviour:
- Reset values: in_ready=0, ready=0, out_valid=0, out_data=0, out_last=0, done=0, FSM=IDLE, counters=0. Memory contents are retained but undefined; benches must not rely on them.
- FSM IDLE -> LOAD:
  - IDLE goes to LOAD on the next cycle unconditionally.
  - LOAD: in_ready=1. Each handshake writes img[cnt] and increments cnt. The handshake with cnt=4095 goes to START.
- FSM START -> RUN:
  - START: ready=1 and held until busy=1 is sampled. On that edge ready drops and the FSM goes to RUN.
- FSM RUN -> DUMP_L0:
  - RUN: serves the CONV. Goes to DUMP_L0 on the first cycle busy=0 is sampled after entering RUN (falling edge of busy).
- FSM DUMP_L0 -> DUMP_L1:
  - DUMP_L0: out_data=L0[cnt], registered; the first word is valid one cycle after entry.
  - Valid/ready rule: out_valid stays high and out_data stays stable until out_ready.
  - The handshake on cnt=4095 goes to DUMP_L1 with cnt=0, with no bubble required.
- FSM DUMP_L1 -> DONE -> IDLE:
  - DUMP_L1: same rule over 1024 words; out_last=1 with word 1023.
  - On the final handshake: FSM to DONE, out_valid=0.
  - DONE: done=1 for one cycle, then IDLE.
- Memory access rules:
  - idata = img[iaddr] combinational in all states.
  - cdata_rd = L0[caddr_rd] for csel=001, L1[caddr_rd[9:0]] for csel=011, else 0. Independent of crd; crd is advisory only.
  - Writes: on the clk edge with cwr=1 and FSM=RUN, L0[caddr_wr] or L1[caddr_wr[9:0]] is written per csel.
  - cwr outside RUN is ignored. csel not 001/011 is ignored.
- Read-during-write, same address and bank: cdata_rd returns the old value that cycle and the new value the next cycle.
- LOAD is the only path that writes img. in_valid outside LOAD is not acknowledged.
- Reset mid-operation (any state): immediate return to IDLE; in-flight stream words are dropped.

Decomposition:
- Shared package conv_pkg holds:
  - DW, AW
  - CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011
  - IMG_WORDS, L1_WORDS
  - host state encoding: IDLE, LOAD, START, RUN, DUMP_L0, DUMP_L1, DONE
- One natural sub-module: conv_bank_ram (single write port, async read port, parameterised depth). Instantiated three times.

Test Plan:
- Load ramp in_data=addr for 4096 words, busy=0 -> in_ready falls after word 4095; ready=1 next cycle; idata at iaddr=0x0A5 equals 0x000A5.
- In START, raise busy 3 cycles later -> ready stays 1 through those cycles and is 0 the cycle after busy is sampled high; FSM in RUN.
- In RUN: cwr=1, csel=001, caddr_wr=5, cdata_wr=0x12345 -> cdata_rd=0x12345 at caddr_rd=5 with csel=001 from next cycle. Same write with csel=010 leaves L1[5] and L0[5] unchanged.
- L1 write with caddr_wr=0x7FF (csel=011) -> lands at L1[0x3FF]; read at caddr_rd=0x3FF returns it.
- Drop busy, toggle out_ready 1/0 every cycle -> 5120 words in order L0[0..4095] then L1[0..1023]; data stable while stalled; out_last only on word 5120; done pulses once.
- Assert reset after 100 LOAD words -> all outputs at reset values the same cycle; restarted load accepts 4096 fresh words.
